mux_scan_n: RTL and testbench



---
 rtl/mux_scan_n.sv | 112 +++++++++++
 tb/tb_mux_scan_n.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_n.sv
// mux_scan_n: N-channel, W-bit registered multiplexer with manual select,
// round-robin scan with a programmable dwell time, and a sample-and-hold freeze.
// Every output comes from a register, so there is no combinational path from
// the inputs to the outputs.
module mux_scan_n #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int DWELL    = 8,
    localparam int SELW    = $clog2(CHANNELS)
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [SELW-1:0]           sel,
    input  logic                      mode,
    input  logic                      hold,
    output logic [WIDTH-1:0]          out,
    output logic [SELW-1:0]           chan,
    output logic                      tick
);

    localparam int CNTW = $clog2(DWELL + 1);

    // Constants sized to their comparison partners to keep the compares width-exact.
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DWELL - 1);
    localparam logic [SELW-1:0] CH_LAST  = SELW'(CHANNELS - 1);
    localparam logic [SELW:0]   CH_COUNT = (SELW + 1)'(CHANNELS);

    // Operating state is decoded fresh every cycle from the inputs; it is not stored.
    typedef enum logic [1:0] {
        OP_MANUAL,
        OP_SCAN,
        OP_HOLD
    } op_e;

    op_e                op;
    logic [SELW-1:0]    chan_reg, chan_next;
    logic [CNTW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0]   out_reg, out_next;
    logic               tick_reg, tick_next;
    logic [WIDTH-1:0]   ch_data [CHANNELS];

    // Unpack the flat input bus into one entry per channel.
    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_unpack
            assign ch_data[gi] = data_in[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Decode the operating state: hold overrides mode.
    always_comb begin
        op = OP_MANUAL;
        if (hold) begin
            op = OP_HOLD;
        end else if (mode) begin
            op = OP_SCAN;
        end
    end

    // Next-state logic for the channel, the dwell counter, the output data and tick.
    always_comb begin
        chan_next = chan_reg;
        cnt_next  = cnt_reg;
        out_next  = out_reg;
        tick_next = 1'b0;
        case (op)
            OP_MANUAL: begin
                // Requests for channels that do not exist are ignored.
                if ({1'b0, sel} < CH_COUNT) begin
                    chan_next = sel;
                end
                cnt_next = '0;
            end
            OP_SCAN: begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_next  = '0;
                    chan_next = (chan_reg == CH_LAST) ? '0 : chan_reg + 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                // Hold: everything keeps its value and out stops tracking data_in.
            end
        endcase
        if (op != OP_HOLD) begin
            out_next  = ch_data[chan_next];
            tick_next = (chan_next != chan_reg);
        end
    end

    // State registers; the asynchronous reset aborts any scan or hold in progress.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            chan_reg <= '0;
            cnt_reg  <= '0;
            out_reg  <= '0;
            tick_reg <= 1'b0;
        end else begin
            chan_reg <= chan_next;
            cnt_reg  <= cnt_next;
            out_reg  <= out_next;
            tick_reg <= tick_next;
        end
    end

    assign out  = out_reg;
    assign chan = chan_reg;
    assign tick = tick_reg;

endmodule

// File: tb/tb_mux_scan_n.sv
// Directed testbench for mux_scan_n. dut4 uses 4 channels with a dwell of 3;
// dut3 uses 3 channels (for the out-of-range select case) with a dwell of 1
// (tick stays high while scanning). Channel data is ch3..ch0 = D,C,B,A.
module tb_mux_scan_n;

    localparam logic [3:0] A = 4'hA;
    localparam logic [3:0] B = 4'hB;
    localparam logic [3:0] C = 4'hC;
    localparam logic [3:0] D = 4'hD;

    logic        clk;
    logic        resetn;
    logic [1:0]  sel;
    logic        mode;
    logic        hold;
    logic [15:0] data4;
    logic [11:0] data3;
    logic [3:0]  out4, out3;
    logic [1:0]  chan4, chan3;
    logic        tick4, tick3;

    int vec_count  = 0;
    int miss_count = 0;

    // Expected readings for the scan rotation; entry 0 is the value before the first scan edge.
    logic [3:0] rot4 [13] = '{A, A, A, B, B, B, C, C, C, D, D, D, A};
    logic       rtk4 [13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [3:0] rot3 [13] = '{A, B, C, A, B, C, A, B, C, A, B, C, A};

    mux_scan_n #(.WIDTH(4), .CHANNELS(4), .DWELL(3)) dut4 (
        .clock   (clk),
        .resetn  (resetn),
        .data_in (data4),
        .sel     (sel),
        .mode    (mode),
        .hold    (hold),
        .out     (out4),
        .chan    (chan4),
        .tick    (tick4)
    );

    mux_scan_n #(.WIDTH(4), .CHANNELS(3), .DWELL(1)) dut3 (
        .clock   (clk),
        .resetn  (resetn),
        .data_in (data3),
        .sel     (sel),
        .mode    (mode),
        .hold    (hold),
        .out     (out3),
        .chan    (chan3),
        .tick    (tick3)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_count++;
        if (got !== exp) begin
            miss_count++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Main directed sequence.
    initial begin
        resetn = 1'b0;
        mode   = 1'b0;
        hold   = 1'b0;
        sel    = 2'd0;
        data4  = {D, C, B, A};
        data3  = {C, B, A};

        // Reset state while held in reset across edges
        step();
        step();
        check("rst out", out4, 0);
        check("rst chan", chan4, 0);
        check("rst tick", tick4, 0);

        // Move away from zero, then reset between edges
        @(negedge clk);
        resetn = 1'b1;
        sel    = 2'd2;
        step();
        check("pre-async chan", chan4, 2);
        #2 resetn = 1'b0;
        #1;
        check("async out", out4, 0);
        check("async chan", chan4, 0);
        check("async tick", tick4, 0);
        check("async out3", out3, 0);

        // Manual select after release
        @(negedge clk);
        resetn = 1'b1;
        step();
        check("man out", out4, C);
        check("man chan", chan4, 2);
        check("man tick", tick4, 1);
        step();
        check("man tick low", tick4, 0);
        check("man out stay", out4, C);

        // Out-of-range request on the 3-channel instance
        sel = 2'd3;
        step();
        check("oor chan3", chan3, 2);
        check("oor out3", out3, C);
        check("oor tick3", tick3, 0);
        check("sel3 out4", out4, D);
        sel = 2'd1;
        step();
        check("sel1 out3", out3, B);
        check("sel1 chan3", chan3, 1);
        check("sel1 tick3", tick3, 1);

        // Scan rotation from chan=0, cnt=0
        sel = 2'd0;
        step();
        check("to0 chan", chan4, 0);
        mode = 1'b1;
        for (int i = 0; i < 13; i++) begin
            if (i > 0) begin
                step();
                check($sformatf("rot%0d tick", i), tick4, rtk4[i]);
                check($sformatf("rot%0d out3", i), out3, rot3[i]);
                check($sformatf("rot%0d tick3", i), tick3, 1);
            end
            check($sformatf("rot%0d out", i), out4, rot4[i]);
        end

        // Hold mid-dwell at chan=1, cnt=1
        repeat (4) step();
        check("pre-hold chan", chan4, 1);
        check("pre-hold out", out4, B);
        hold = 1'b1;
        data4[7:4] = 4'h7;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("hold%0d out", i), out4, B);
            check($sformatf("hold%0d chan", i), chan4, 1);
            check($sformatf("hold%0d tick", i), tick4, 0);
        end
        hold = 1'b0;
        step();
        check("unhold out", out4, 7);
        check("unhold chan", chan4, 1);
        check("unhold tick", tick4, 0);
        step();
        check("unhold adv out", out4, C);
        check("unhold adv tick", tick4, 1);
        data4[7:4] = B;

        // Scan to chan=3, then switch to manual and back to scan
        repeat (3) step();
        check("at3 chan", chan4, 3);
        check("at3 out", out4, D);
        mode = 1'b0;
        sel  = 2'd0;
        step();
        check("sw chan", chan4, 0);
        check("sw out", out4, A);
        check("sw tick", tick4, 1);
        mode = 1'b1;
        step();
        check("rescan1 chan", chan4, 0);
        check("rescan1 tick", tick4, 0);
        step();
        check("rescan2 chan", chan4, 0);
        step();
        check("rescan3 chan", chan4, 1);
        check("rescan3 out", out4, B);
        check("rescan3 tick", tick4, 1);

        // Hold over a would-be advance
        repeat (2) step();
        check("edge chan", chan4, 1);
        hold = 1'b1;
        repeat (2) step();
        check("hadv chan", chan4, 1);
        check("hadv tick", tick4, 0);
        hold = 1'b0;
        step();
        check("hadv rel chan", chan4, 2);
        check("hadv rel out", out4, C);
        check("hadv rel tick", tick4, 1);

        // Reset mid-scan at chan=2, cnt=2
        repeat (2) step();
        check("mid chan", chan4, 2);
        #2 resetn = 1'b0;
        #1;
        check("midrst out", out4, 0);
        check("midrst chan", chan4, 0);
        check("midrst tick", tick4, 0);
        @(negedge clk);
        resetn = 1'b1;
        step();
        check("post1 out", out4, A);
        check("post1 tick", tick4, 0);
        step();
        check("post2 out", out4, A);
        step();
        check("post3 out", out4, B);
        check("post3 chan", chan4, 1);
        check("post3 tick", tick4, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
